// File: rtl/knn_vote.sv
// knn_vote: majority-vote stage after the KNN distance sorter.
// Counts class votes among the first K entries of each sorted frame, discards
// the rest of the frame, then scans the counters (one class per cycle) and
// presents the winning class on a valid/ready output.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   in_valid     input entry valid
//   in_ready     block accepts input (registered)
//   in_dist      entry distance, sorted ascending
//   in_label     entry class label
//   in_last      final entry of the frame
//   out_valid    result valid (registered)
//   out_ready    consumer accepts result
//   out_class    winning class (lowest index wins ties)
//   out_count    votes of the winning class (0 = no decision)
//   out_nearest  distance of the rank-0 entry of the frame
module knn_vote #(
    parameter int unsigned K           = 5,
    parameter int unsigned N           = 64,
    parameter int unsigned NUM_CLASSES = 3,
    parameter int unsigned LABEL_W     = 2,
    parameter int unsigned DIST_W      = 16,
    parameter int unsigned CNT_W       = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIST_W-1:0]  in_dist,
    input  logic [LABEL_W-1:0] in_label,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LABEL_W-1:0] out_class,
    output logic [CNT_W-1:0]   out_count,
    output logic [DIST_W-1:0]  out_nearest
);

    localparam int unsigned RANK_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SKIP    = 2'd1,
        VOTE    = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 in_ready_d;
    logic                 out_valid_d;

    logic [RANK_W-1:0]    rank;
    logic [CNT_W-1:0]     count [NUM_CLASSES];
    logic [DIST_W-1:0]    nearest;
    logic [LABEL_W-1:0]   best_class;
    logic [CNT_W-1:0]     best_count;
    logic [LABEL_W-1:0]   scan;

    logic                 in_fire;
    logic                 out_fire;
    logic                 frame_end;
    logic                 label_ok;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    // Rank N-1 closes the frame even when upstream never flags in_last.
    assign frame_end = in_last || (rank == RANK_W'(N - 1));
    assign label_ok  = (32'(in_label) < NUM_CLASSES);

    // Next-state and registered-output decode
    always_comb begin
        state_next  = state;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state)
            COLLECT: begin
                if (in_fire) begin
                    if (frame_end) begin
                        state_next = VOTE;
                    end else if (rank == RANK_W'(K - 1)) begin
                        state_next = SKIP;
                    end
                end
            end
            SKIP: begin
                if (in_fire && frame_end) begin
                    state_next = VOTE;
                end
            end
            VOTE: begin
                if (scan == LABEL_W'(NUM_CLASSES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_fire) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
        in_ready_d  = (state_next == COLLECT) || (state_next == SKIP);
        out_valid_d = (state_next == DONE);
    end

    // State register; handshake flags follow the next state so they never
    // depend combinationally on inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= COLLECT;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Vote counters, rank, nearest distance and running best
    always_ff @(posedge clk) begin
        if (rst) begin
            rank       <= '0;
            nearest    <= '0;
            best_class <= '0;
            best_count <= '0;
            scan       <= '0;
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                count[i] <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (in_fire) begin
                        rank <= rank + RANK_W'(1);
                        if (rank == '0) begin
                            nearest <= in_dist;
                        end
                        // Out-of-range labels use up a rank but do not vote.
                        if (label_ok && (count[in_label] != CNT_W'(K))) begin
                            count[in_label] <= count[in_label] + CNT_W'(1);
                        end
                    end
                end
                SKIP: begin
                    if (in_fire) begin
                        rank <= rank + RANK_W'(1);
                    end
                end
                VOTE: begin
                    // Strict compare keeps the lowest class index on ties.
                    if (count[scan] > best_count) begin
                        best_class <= scan;
                        best_count <= count[scan];
                    end
                    scan <= scan + LABEL_W'(1);
                end
                DONE: begin
                    if (out_fire) begin
                        rank       <= '0;
                        nearest    <= '0;
                        best_class <= '0;
                        best_count <= '0;
                        scan       <= '0;
                        for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                            count[i] <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_class   = best_class;
    assign out_count   = best_count;
    assign out_nearest = nearest;

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed frames from the test plan plus
// randomized frames against a frame-level vote model.
module tb_knn_vote;

    localparam int unsigned K   = 5;
    localparam int unsigned N   = 64;
    localparam int unsigned NC  = 3;
    localparam int unsigned LW  = 2;
    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = $clog2(K + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_dist;
    logic [LW-1:0] in_label;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_class;
    logic [CW-1:0] out_count;
    logic [DW-1:0] out_nearest;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] fd[$];
    logic [LW-1:0] fl[$];

    knn_vote #(.K(K), .N(N), .NUM_CLASSES(NC), .LABEL_W(LW), .DIST_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_dist    (in_dist),
        .in_label   (in_label),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_count  (out_count),
        .out_nearest(out_nearest)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Frame-level reference: votes among the first K entries of the frame
    // (frame ends at in_last or at entry N-1), winner = highest vote count,
    // lowest class among equals, class 0 when nobody voted.
    task automatic model(input bit use_last, output int cls, output int cnt, output int nr);
        int votes [4];
        int last_idx;
        int top;
        last_idx = use_last ? fd.size() - 1 : N - 1;
        if (last_idx > N - 1) last_idx = N - 1;
        foreach (votes[c]) votes[c] = 0;
        for (int i = 0; i <= last_idx && i < int'(K); i++) begin
            if (int'(fl[i]) < int'(NC)) votes[fl[i]]++;
        end
        top = 0;
        for (int c = 0; c < int'(NC); c++) if (votes[c] > top) top = votes[c];
        cls = 0;
        for (int c = int'(NC) - 1; c >= 0; c--) if (top > 0 && votes[c] == top) cls = c;
        cnt = top;
        nr  = int'(fd[0]);
    endtask

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic push(input logic [DW-1:0] d, input logic [LW-1:0] l, input logic last);
        int guard = 0;
        in_valid = 1'b1;
        in_dist  = d;
        in_label = l;
        in_last  = last;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("push_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input bit use_last, input bit gaps, output int e0);
        for (int i = 0; i < fd.size(); i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            push(fd[i], fl[i], use_last && (i == fd.size() - 1));
        end
        e0 = cyc;
    endtask

    task automatic get_result(input string tag, input int ec, input int ecnt, input int enr,
                              input int hold, output int vcyc);
        int g = 0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        vcyc = cyc;
        check({tag, "_valid"}, int'(out_valid), 1);
        check({tag, "_class"}, int'(out_class), ec);
        check({tag, "_count"}, int'(out_count), ecnt);
        check({tag, "_nearest"}, int'(out_nearest), enr);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, int'(out_valid), 1);
            check({tag, "_hold_class"}, int'(out_class), ec);
            check({tag, "_hold_count"}, int'(out_count), ecnt);
            check({tag, "_hold_nearest"}, int'(out_nearest), enr);
            check({tag, "_hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_valid"}, int'(out_valid), 0);
        check({tag, "_post_in_ready"}, int'(in_ready), 1);
    endtask

    task automatic load5(input int l0, input int l1, input int l2, input int l3, input int l4);
        int ls [5];
        ls = '{l0, l1, l2, l3, l4};
        fd.delete();
        fl.delete();
        for (int i = 0; i < 5; i++) begin
            fd.push_back(DW'(i * 3));
            fl.push_back(LW'(ls[i]));
        end
    endtask

    task automatic run_frame(input string tag, input bit use_last, input bit gaps,
                             input int hold, input int ec, input int ecnt, input int enr);
        int e0, vc, mc, mn, mr;
        model(use_last, mc, mn, mr);
        // Directed expectations are also held against the model.
        check({tag, "_model_class"}, mc, ec);
        check({tag, "_model_count"}, mn, ecnt);
        send_frame(use_last, gaps, e0);
        get_result(tag, ec, ecnt, enr, hold, vc);
    endtask

    initial begin
        int e0, vc, mc, mn, mr, len;
        bit ul;
        logic [DW-1:0] d;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_dist   = '0;
        in_label  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_class", int'(out_class), 0);
        check("rst_out_count", int'(out_count), 0);
        check("rst_out_nearest", int'(out_nearest), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", int'(in_ready), 1);

        // 64-entry frame, latency from the in_last edge to out_valid
        load5(2, 1, 2, 0, 2);
        for (int i = 5; i < 64; i++) begin
            fd.push_back(DW'(i * 3));
            fl.push_back(LW'(1));
        end
        send_frame(1'b1, 1'b0, e0);
        get_result("full64", 2, 3, 0, 0, vc);
        check("full64_latency", vc - e0, int'(NC));

        load5(1, 0, 0, 1, 2);
        run_frame("tie01", 1'b1, 1'b0, 0, 0, 2, 0);
        load5(2, 1, 1, 2, 0);
        run_frame("tie12", 1'b1, 1'b1, 0, 1, 2, 0);

        fd.delete(); fl.delete();
        fd.push_back(16'd7);  fl.push_back(2'd2);
        fd.push_back(16'd9);  fl.push_back(2'd2);
        fd.push_back(16'd12); fl.push_back(2'd0);
        run_frame("short3", 1'b1, 1'b0, 0, 2, 2, 7);

        load5(3, 3, 3, 1, 3);
        run_frame("oor_one", 1'b1, 1'b0, 0, 1, 1, 0);
        load5(3, 3, 3, 3, 3);
        run_frame("oor_none", 1'b1, 1'b0, 0, 0, 0, 0);

        // Backpressure hold, then an independent frame
        load5(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++) fd[i] = DW'(100 + i);
        run_frame("hold10", 1'b1, 1'b0, 10, 1, 3, 100);
        load5(2, 0, 2, 0, 0);
        run_frame("after_hold", 1'b1, 1'b0, 0, 0, 3, 0);

        // Reset mid-frame
        push(16'd5, 2'd1, 1'b0);
        push(16'd6, 2'd1, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_out_class", int'(out_class), 0);
        check("midrst_out_count", int'(out_count), 0);
        check("midrst_out_nearest", int'(out_nearest), 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_in_ready", int'(in_ready), 1);
        load5(0, 0, 1, 0, 2);
        run_frame("after_rst", 1'b1, 1'b0, 0, 0, 3, 0);

        // Randomized frames, including frames forced closed at entry N-1
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 64);
            if (f % 6 == 5) len = 64;
            ul  = (len < 64) || ($urandom_range(0, 1) == 0);
            fd.delete();
            fl.delete();
            d = DW'($urandom_range(0, 1000));
            for (int i = 0; i < len; i++) begin
                fd.push_back(d);
                fl.push_back(LW'($urandom_range(0, 3)));
                d = d + DW'($urandom_range(0, 40));
            end
            model(ul, mc, mn, mr);
            send_frame(ul, 1'b1, e0);
            get_result($sformatf("rand%0d", f), mc, mn, mr, $urandom_range(0, 3), vc);
            check($sformatf("rand%0d_latency", f), vc - e0, int'(NC));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/knn_vote.md
# knn_vote

Majority-vote stage downstream of the distance sorter in the KNN classifier. It consumes the sorted neighbour stream, nearest first, as (distance, label) pairs over a valid/ready handshake. It counts class votes among the first K entries, discards the rest of the frame, then scans the vote counters to produce one classification result per frame. The result is presented on a valid/ready output.

## Interface
- K, 5, number of nearest neighbours that vote (1..N)
- N, 64, maximum entries per frame (sizes the rank counter)
- NUM_CLASSES, 3, number of valid class labels (2..2^LABEL_W)
- LABEL_W, 2, label width
- DIST_W, 16, unsigned fixed-point distance width
- CNT_W, $clog2(K+1), vote counter width
- clk  in  1  clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input entry valid
- in_ready  out  1  block accepts input
- in_dist  in  DIST_W  entry distance (already sorted ascending)
- in_label  in  LABEL_W  entry class label
- in_last  in  1  final entry of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  LABEL_W  winning class
- out_count  out  CNT_W  votes of winning class
- out_nearest  out  DIST_W  distance of rank-0 entry of the frame

## Operation
- Handshake: a transfer occurs on a rising edge with valid and ready both high. out_* fields hold stable while out_valid=1 and out_ready=0.
- States: COLLECT, SKIP, VOTE, DONE. Reset state is COLLECT.
- COLLECT: in_ready=1. Each accepted entry increments rank (0-based).
  - rank 0 captures in_dist into the nearest register.
  - If in_label < NUM_CLASSES, increment count[in_label]. Out-of-range labels consume a rank but cast no vote.
  - On acceptance of the entry with rank K-1: in_last=1 goes to VOTE, else SKIP.
  - in_last=1 with rank < K-1 (short frame) goes to VOTE with the votes gathered so far.
- SKIP: in_ready=1. Entries are discarded without affecting counts. Accepted in_last goes to VOTE.
- VOTE: in_ready=0. Scans class c = 0..NUM_CLASSES-1, one class per cycle.
  - best is replaced only if count[c] > best_count (strict).
  - Ties therefore resolve to the lowest class index.
  - best is initialised to class 0 with count 0.
  - After class NUM_CLASSES-1, go to DONE.
- DONE: in_ready=0, out_valid=1. On out_ready, clear all counts, rank and best, and return to COLLECT.
- Frames with no valid votes produce out_class=0 and out_count=0. The consumer treats out_count=0 as "no decision".
- Counts saturate at K. They cannot exceed K by construction.
- A rank counter reaching N-1 without in_last forces VOTE on that entry, as if in_last were set.

## Timing
- Reset (rst sampled high): state COLLECT, all counts 0, in_ready=0 during the reset cycle, out_valid=0, out_class=0, out_count=0, out_nearest=0.
  - in_ready=1 from the first cycle after rst deasserts.
- Reset mid-frame or while out_valid=1 aborts the frame and discards the pending result. Upstream restarts the frame.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs. Throughput in COLLECT/SKIP is one entry per cycle.
- Latency: with in_last accepted at edge E0, VOTE occupies edges E0+1 .. E0+NUM_CLASSES. out_valid is high in the cycle after edge E0+NUM_CLASSES.
- The result is accepted at edge Ea. in_ready=1 in the cycle after Ea, so minimum frame-to-frame gap is NUM_CLASSES+1 cycles with in_ready=0.
- No input is accepted while a result is pending (no overlap of frames).

## Test plan
- Frame of 64 entries, dist=i*3, labels 2,1,2,0,2 then label 1 for the rest, in_last on entry 63 -> out_class=2, out_count=3, out_nearest=0. out_valid rises 3 cycles after the in_last edge.
- First five labels 1,0,0,1,2 -> tie between 0 and 1 -> out_class=0, out_count=2. Labels 2,1,1,2,0 -> out_class=1, out_count=2.
- Short frame of 3 entries, labels 2,2,0, dist 7,9,12, in_last on the third -> out_class=2, out_count=2, out_nearest=7.
- Labels 3,3,3,1,3 (3 out of range) -> out_class=1, out_count=1. All five labels 3 -> out_class=0, out_count=0.
- out_ready held low 10 cycles after out_valid -> outputs stable, in_ready=0 throughout. A second frame sent after acceptance gives an independent result, with no carry-over of counts.
- rst pulsed after 2 entries of a frame -> outputs zeroed. A following full frame with labels 0,0,1,0,2 yields out_class=0, out_count=3.
